// File: rtl/tmr_irq_arbiter.sv
// -----------------------------------------------------------------------------
// tmr_irq_arbiter
//
// Turns single-cycle event pulses from a bank of timers into interrupt
// requests. Each timer owns three pending flags {ovf, match1, match0} and one
// sticky overrun flag. Timers with a pending event and an unmasked interrupt
// compete in round-robin order. The winner is presented to the consumer as one
// request over a req/ack handshake.
//
// Ports
//   sys_clk      : system clock
//   sys_rst_n    : synchronous active-low reset
//   evt_match0   : per-timer match0 event pulse
//   evt_match1   : per-timer match1 event pulse
//   evt_ovf      : per-timer overflow event pulse
//   irq_mask     : per-timer enable; 1 = eligible for arbitration
//   irq_ack      : consumer accepts the current request
//   irq_req      : request valid; held until irq_ack
//   irq_tmr_id   : index of the granted timer
//   irq_src      : captured pending bitmap {ovf, match1, match0}
//   irq_ovr      : granted timer lost at least one event
//   pend_o       : live pending flags; timer i occupies bits [3i+2:3i]
// -----------------------------------------------------------------------------
module tmr_irq_arbiter #(
  parameter int NUM_TMR = 4,
  parameter int ID_W    = $clog2(NUM_TMR)
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst_n,
  input  logic [NUM_TMR-1:0]     evt_match0,
  input  logic [NUM_TMR-1:0]     evt_match1,
  input  logic [NUM_TMR-1:0]     evt_ovf,
  input  logic [NUM_TMR-1:0]     irq_mask,
  input  logic                   irq_ack,
  output logic                   irq_req,
  output logic [ID_W-1:0]        irq_tmr_id,
  output logic [2:0]             irq_src,
  output logic                   irq_ovr,
  output logic [3*NUM_TMR-1:0]   pend_o
);

  // One extra bit so last_grant + k (k up to NUM_TMR) never wraps before the
  // explicit modulo correction below.
  localparam int IDX_W = ID_W + 1;

  typedef enum logic {
    ST_IDLE,
    ST_REQ
  } state_t;

  state_t                    r_state;
  logic                      r_req;
  logic [ID_W-1:0]           r_id;
  logic [ID_W-1:0]           r_last;
  logic [2:0]                r_src;
  logic                      r_ovr_gnt;
  logic [NUM_TMR-1:0][2:0]   r_pend;
  logic [NUM_TMR-1:0]        r_ovr;

  logic                      w_ack_fire;
  logic [NUM_TMR-1:0][2:0]   w_evt;
  logic [NUM_TMR-1:0][2:0]   w_clr;
  logic [NUM_TMR-1:0][2:0]   w_pend_nxt;
  logic [NUM_TMR-1:0]        w_ovr_nxt;
  logic [NUM_TMR-1:0]        w_cand;
  logic                      w_found;
  logic [ID_W-1:0]           w_pick;
  logic [IDX_W-1:0]          w_idx;

  // An ack only counts while a request is outstanding.
  assign w_ack_fire = (r_state == ST_REQ) && irq_ack;

  // Pending/overrun next-state. A new pulse beats a clear of the same bit, and
  // a bit that is being cleared on this edge cannot be overrun by that pulse.
  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_evt      = '0;
    w_clr      = '0;
    w_pend_nxt = '0;
    w_ovr_nxt  = '0;
    w_cand     = '0;
    for (int i = 0; i < NUM_TMR; i++) begin
      w_evt[i] = {evt_ovf[i], evt_match1[i], evt_match0[i]};
      if (w_ack_fire && (r_id == ID_W'(i))) begin
        w_clr[i] = r_src;
      end
      w_pend_nxt[i] = (r_pend[i] & ~w_clr[i]) | w_evt[i];
      w_ovr_nxt[i]  = (r_ovr[i] & ~(w_ack_fire && (r_id == ID_W'(i))))
                    | (|(w_evt[i] & r_pend[i] & ~w_clr[i]));
      w_cand[i]     = (|r_pend[i]) & irq_mask[i];
    end
  end

  // Round-robin search: first candidate at or after last_grant+1, wrapping.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    w_idx   = '0;
    for (int k = 1; k <= NUM_TMR; k++) begin
      w_idx = {1'b0, r_last} + IDX_W'(k);
      if (w_idx >= IDX_W'(NUM_TMR)) begin
        w_idx = w_idx - IDX_W'(NUM_TMR);
      end
      if (!w_found && w_cand[w_idx[ID_W-1:0]]) begin
        w_found = 1'b1;
        w_pick  = w_idx[ID_W-1:0];
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of block evaluation order.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      r_pend <= '0;
      r_ovr  <= '0;
    end else begin
      r_pend <= w_pend_nxt;
      r_ovr  <= w_ovr_nxt;
    end
  end

  // Request FSM with registered outputs. Once raised, the request payload is
  // frozen until acknowledged, even if the mask drops or new events arrive.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      r_state   <= ST_IDLE;
      r_req     <= 1'b0;
      r_id      <= '0;
      r_src     <= '0;
      r_ovr_gnt <= 1'b0;
      r_last    <= ID_W'(NUM_TMR - 1);
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_found) begin
            r_state   <= ST_REQ;
            r_req     <= 1'b1;
            r_id      <= w_pick;
            r_src     <= r_pend[w_pick];
            r_ovr_gnt <= r_ovr[w_pick];
          end
        end
        ST_REQ: begin
          if (irq_ack) begin
            r_state <= ST_IDLE;
            r_req   <= 1'b0;
            r_last  <= r_id;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_req   <= 1'b0;
        end
      endcase
    end
  end

  assign irq_req    = r_req;
  assign irq_tmr_id = r_id;
  assign irq_src    = r_src;
  assign irq_ovr    = r_ovr_gnt;
  assign pend_o     = r_pend;

endmodule
